// File: rtl/id_ex_stage_if.sv
// ID/EX stage bundle: fetch input, register-file read/writeback ports and ID/EX outputs.
// No latency of its own; it only carries signals.
// The stall_if request travels back to fetch over this bundle.
interface id_ex_stage_if;
  // fetch side
  logic        if_valid;
  logic [31:0] instr;
  logic        flush;
  logic        stall_if;
  // register-file read port
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  // register-file write port (writeback stage)
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  // ID/EX pipeline register
  logic        ex_valid;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_alu_src;
  logic        ex_branch;
  logic [2:0]  ex_alu_op;
  logic [31:0] ex_rs_val;
  logic [31:0] ex_rt_val;
  logic [31:0] ex_imm;
  logic [4:0]  ex_dest;
  logic        ex_illegal;

  // environment side: fetch, register file and writeback
  modport master (
    output if_valid, instr, flush, rs_data, rt_data, wb_reg_write, wb_rd, wb_data,
    input  stall_if, rs, rt, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
           ex_alu_src, ex_branch, ex_alu_op, ex_rs_val, ex_rt_val, ex_imm, ex_dest,
           ex_illegal
  );

  // decode stage side
  modport slave (
    input  if_valid, instr, flush, rs_data, rt_data, wb_reg_write, wb_rd, wb_data,
    output stall_if, rs, rt, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
           ex_alu_src, ex_branch, ex_alu_op, ex_rs_val, ex_rt_val, ex_imm, ex_dest,
           ex_illegal
  );
endinterface

// File: rtl/id_ex_stage.sv
// Decode stage: decodes instr, reads operands (with writeback bypass) into the ID/EX register.
// Latency: one clk edge from instr to ex_* outputs; rs/rt/stall_if are combinational.
// Backpressure: a load-use hazard raises stall_if for one cycle and inserts one bubble.
module id_ex_stage #(
  parameter int unsigned WB_BYPASS = 1
) (
  input  logic clk,
  input  logic rst_n,
  id_ex_stage_if.slave io
);

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  typedef enum logic {RUN = 1'b0, LU_STALL = 1'b1} state_t;

  state_t state, state_nxt;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs_a;
  logic [4:0]  rt_a;
  logic [4:0]  rd_a;
  logic [15:0] imm16;

  logic        d_ok;
  logic [2:0]  d_op;
  logic        d_rw;
  logic        d_mr;
  logic        d_mw;
  logic        d_as;
  logic        d_br;
  logic [4:0]  d_dest;
  logic        d_use_rt;
  logic        d_zext;
  logic [31:0] d_imm;

  logic        is_nop;
  logic        cur_valid;
  logic        hazard;
  logic        issue;
  logic        set_illegal;
  logic        stall;
  logic [31:0] rs_val;
  logic [31:0] rt_val;

  assign opcode = io.instr[31:26];
  assign rs_a   = io.instr[25:21];
  assign rt_a   = io.instr[20:16];
  assign rd_a   = io.instr[15:11];
  assign imm16  = io.instr[15:0];
  assign funct  = io.instr[5:0];
  assign is_nop = (io.instr == 32'd0);

  assign io.rs = rs_a;
  assign io.rt = rt_a;

  // Instruction decode: control bits, destination and which sources are read.
  always_comb begin
    d_ok     = 1'b0;
    d_op     = ALU_ADD;
    d_rw     = 1'b0;
    d_mr     = 1'b0;
    d_mw     = 1'b0;
    d_as     = 1'b0;
    d_br     = 1'b0;
    d_dest   = 5'd0;
    d_use_rt = 1'b0;
    d_zext   = 1'b0;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h20: begin d_ok = 1'b1; d_op = ALU_ADD; end
          6'h22: begin d_ok = 1'b1; d_op = ALU_SUB; end
          6'h24: begin d_ok = 1'b1; d_op = ALU_AND; end
          6'h25: begin d_ok = 1'b1; d_op = ALU_OR;  end
          6'h2A: begin d_ok = 1'b1; d_op = ALU_SLT; end
          default: d_ok = 1'b0;
        endcase
        if (d_ok) begin
          d_rw     = 1'b1;
          d_dest   = rd_a;
          d_use_rt = 1'b1;
        end
      end
      6'h08: begin d_ok = 1'b1; d_op = ALU_ADD; d_rw = 1'b1; d_as = 1'b1; d_dest = rt_a; end
      6'h0C: begin d_ok = 1'b1; d_op = ALU_AND; d_rw = 1'b1; d_as = 1'b1; d_dest = rt_a; d_zext = 1'b1; end
      6'h0D: begin d_ok = 1'b1; d_op = ALU_OR;  d_rw = 1'b1; d_as = 1'b1; d_dest = rt_a; d_zext = 1'b1; end
      6'h23: begin d_ok = 1'b1; d_op = ALU_ADD; d_rw = 1'b1; d_mr = 1'b1; d_as = 1'b1; d_dest = rt_a; end
      6'h2B: begin d_ok = 1'b1; d_op = ALU_ADD; d_mw = 1'b1; d_as = 1'b1; d_use_rt = 1'b1; end
      6'h04: begin d_ok = 1'b1; d_op = ALU_SUB; d_br = 1'b1; d_use_rt = 1'b1; end
      default: d_ok = 1'b0;
    endcase
  end

  // Logical immediates zero-extend; everything else sign-extends.
  assign d_imm = d_zext ? {16'd0, imm16} : {{16{imm16[15]}}, imm16};

  // Load-use detection: a load sitting in EX whose result the current instruction reads.
  assign cur_valid   = io.if_valid & d_ok;
  assign hazard      = cur_valid & io.ex_valid & io.ex_mem_read & (io.ex_dest != 5'd0) &
                       ((io.ex_dest == rs_a) | (d_use_rt & (io.ex_dest == rt_a)));
  assign set_illegal = io.if_valid & ~d_ok & ~is_nop & ~io.flush;

  // Operand read with same-cycle writeback bypass; x0 is never bypassed.
  always_comb begin
    rs_val = io.rs_data;
    rt_val = io.rt_data;
    if (WB_BYPASS != 0) begin
      if (io.wb_reg_write && (io.wb_rd != 5'd0) && (io.wb_rd == rs_a)) rs_val = io.wb_data;
      if (io.wb_reg_write && (io.wb_rd != 5'd0) && (io.wb_rd == rt_a)) rt_val = io.wb_data;
    end
  end

  // Stall FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  // Stall FSM next state and issue/stall decisions; flush overrides everything.
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    issue     = cur_valid;
    if (io.flush) begin
      state_nxt = RUN;
      issue     = 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (hazard) begin
            state_nxt = LU_STALL;
            stall     = 1'b1;
            issue     = 1'b0;
          end
        end
        LU_STALL: state_nxt = RUN;
        default:  state_nxt = RUN;
      endcase
    end
  end

  assign io.stall_if = stall;

  // ID/EX pipeline register: load the decoded instruction or a fully cleared bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io.ex_valid     <= 1'b0;
      io.ex_reg_write <= 1'b0;
      io.ex_mem_read  <= 1'b0;
      io.ex_mem_write <= 1'b0;
      io.ex_alu_src   <= 1'b0;
      io.ex_branch    <= 1'b0;
      io.ex_alu_op    <= 3'd0;
      io.ex_rs_val    <= 32'd0;
      io.ex_rt_val    <= 32'd0;
      io.ex_imm       <= 32'd0;
      io.ex_dest      <= 5'd0;
    end else if (issue) begin
      io.ex_valid     <= 1'b1;
      io.ex_reg_write <= d_rw;
      io.ex_mem_read  <= d_mr;
      io.ex_mem_write <= d_mw;
      io.ex_alu_src   <= d_as;
      io.ex_branch    <= d_br;
      io.ex_alu_op    <= d_op;
      io.ex_rs_val    <= rs_val;
      io.ex_rt_val    <= rt_val;
      io.ex_imm       <= d_imm;
      io.ex_dest      <= d_dest;
    end else begin
      io.ex_valid     <= 1'b0;
      io.ex_reg_write <= 1'b0;
      io.ex_mem_read  <= 1'b0;
      io.ex_mem_write <= 1'b0;
      io.ex_alu_src   <= 1'b0;
      io.ex_branch    <= 1'b0;
      io.ex_alu_op    <= 3'd0;
      io.ex_rs_val    <= 32'd0;
      io.ex_rt_val    <= 32'd0;
      io.ex_imm       <= 32'd0;
      io.ex_dest      <= 5'd0;
    end
  end

  // Sticky illegal-opcode flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) io.ex_illegal <= 1'b0;
    else        io.ex_illegal <= io.ex_illegal | set_illegal;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected ID/EX contents are queued when an
// instruction is driven and compared one rising edge later.
module tb_id_ex_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_ex_stage_if bus();

  id_ex_stage #(.WB_BYPASS(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  // control bits ordered {reg_write, mem_read, mem_write, alu_src, branch}
  localparam logic [4:0] C_R   = 5'b10000;
  localparam logic [4:0] C_IMM = 5'b10010;
  localparam logic [4:0] C_LW  = 5'b11010;
  localparam logic [4:0] C_SW  = 5'b00110;
  localparam logic [4:0] C_BR  = 5'b00001;

  typedef struct {
    string       tag;
    logic        vld;
    logic [4:0]  ctrl;
    logic [2:0]  op;
    logic [4:0]  dest;
    logic [31:0] rsv;
    logic [31:0] rtv;
    logic [31:0] imm;
    logic        ill;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [2:0] op, input logic [4:0] dest,
                              input logic [31:0] rsv, input logic [31:0] rtv,
                              input logic [31:0] imm, input logic [4:0] ctrl,
                              input logic ill);
    exp_t e;
    e.tag = ""; e.vld = 1'b1; e.ctrl = ctrl; e.op = op; e.dest = dest;
    e.rsv = rsv; e.rtv = rtv; e.imm = imm; e.ill = ill;
    return e;
  endfunction

  function automatic exp_t bub(input logic ill);
    exp_t e;
    e.tag = ""; e.vld = 1'b0; e.ctrl = 5'd0; e.op = 3'd0; e.dest = 5'd0;
    e.rsv = 32'd0; e.rtv = 32'd0; e.imm = 32'd0; e.ill = ill;
    return e;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, ".valid"}, {31'd0, bus.ex_valid}, 32'd0);
    chk({tag, ".ctrl"}, {27'd0, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
                         bus.ex_alu_src, bus.ex_branch}, 32'd0);
    chk({tag, ".data"}, bus.ex_rs_val | bus.ex_rt_val | bus.ex_imm |
                        {24'd0, bus.ex_alu_op, bus.ex_dest}, 32'd0);
    chk({tag, ".illegal"}, {31'd0, bus.ex_illegal}, 32'd0);
  endtask

  // Drive one instruction at the falling edge, check the combinational outputs,
  // then pop and compare the registered result after the next rising edge.
  task automatic step(input string tag, input logic [31:0] i, input logic v, input logic fl,
                      input logic [31:0] rsd, input logic [31:0] rtd,
                      input logic wrw, input logic [4:0] wrd, input logic [31:0] wdat,
                      input logic xstall, input exp_t e);
    exp_t o;
    logic [31:0] iv;
    @(negedge clk);
    bus.instr = i; bus.if_valid = v; bus.flush = fl;
    bus.rs_data = rsd; bus.rt_data = rtd;
    bus.wb_reg_write = wrw; bus.wb_rd = wrd; bus.wb_data = wdat;
    e.tag = tag;
    sb_q.push_back(e);
    iv = i;
    #1;
    chk({tag, ".stall_if"}, {31'd0, bus.stall_if}, {31'd0, xstall});
    chk({tag, ".rs_addr"}, {27'd0, bus.rs}, {27'd0, iv[25:21]});
    chk({tag, ".rt_addr"}, {27'd0, bus.rt}, {27'd0, iv[20:16]});
    @(posedge clk);
    #1;
    o = sb_q.pop_front();
    chk({o.tag, ".valid"}, {31'd0, bus.ex_valid}, {31'd0, o.vld});
    chk({o.tag, ".ctrl"}, {27'd0, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
                           bus.ex_alu_src, bus.ex_branch}, {27'd0, o.ctrl});
    chk({o.tag, ".illegal"}, {31'd0, bus.ex_illegal}, {31'd0, o.ill});
    if (o.vld) begin
      chk({o.tag, ".alu_op"}, {29'd0, bus.ex_alu_op}, {29'd0, o.op});
      chk({o.tag, ".dest"}, {27'd0, bus.ex_dest}, {27'd0, o.dest});
      chk({o.tag, ".rs_val"}, bus.ex_rs_val, o.rsv);
      chk({o.tag, ".rt_val"}, bus.ex_rt_val, o.rtv);
      chk({o.tag, ".imm"}, bus.ex_imm, o.imm);
    end
  endtask

  // Common case: valid instruction, no flush, no writeback activity.
  task automatic run(input string tag, input logic [31:0] i, input logic [31:0] rsd,
                     input logic [31:0] rtd, input logic xstall, input exp_t e);
    step(tag, i, 1'b1, 1'b0, rsd, rtd, 1'b0, 5'd0, 32'd0, xstall, e);
  endtask

  localparam logic [31:0] LW2    = 32'h8C220000; // lw  $2,0($1)
  localparam logic [31:0] ADD322 = 32'h00421820; // add $3,$2,$2

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    bus.if_valid = 1'b1; bus.instr = 32'h00221820; bus.flush = 1'b0;
    bus.rs_data = 32'd5; bus.rt_data = 32'd7;
    bus.wb_reg_write = 1'b0; bus.wb_rd = 5'd0; bus.wb_data = 32'd0;

    // reset holds the stage empty even with a valid instruction presented
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // ALU decode
    run("add",  32'h00221820, 32'd5,   32'd7,   1'b0, mk(3'd0, 5'd3,  32'd5,   32'd7,   32'h1820, C_R, 1'b0));
    run("sub",  32'h00C72822, 32'd20,  32'd3,   1'b0, mk(3'd1, 5'd5,  32'd20,  32'd3,   32'h2822, C_R, 1'b0));
    run("and",  32'h00430824, 32'hF0,  32'h3C,  1'b0, mk(3'd2, 5'd1,  32'hF0,  32'h3C,  32'h0824, C_R, 1'b0));
    run("or",   32'h012A4025, 32'h11,  32'h22,  1'b0, mk(3'd3, 5'd8,  32'h11,  32'h22,  32'h4025, C_R, 1'b0));
    run("slt",  32'h018D582A, 32'h33,  32'h44,  1'b0, mk(3'd4, 5'd11, 32'h33,  32'h44,  32'h582A, C_R, 1'b0));
    run("ori",  32'h34048001, 32'd0,   32'h11,  1'b0, mk(3'd3, 5'd4,  32'd0,   32'h11,  32'h00008001, C_IMM, 1'b0));
    run("addi", 32'h20258001, 32'h100, 32'h22,  1'b0, mk(3'd0, 5'd5,  32'h100, 32'h22,  32'hFFFF8001, C_IMM, 1'b0));
    run("andi", 32'h3026F0F0, 32'd1,   32'd2,   1'b0, mk(3'd2, 5'd6,  32'd1,   32'd2,   32'h0000F0F0, C_IMM, 1'b0));
    run("beq",  32'h10220008, 32'd4,   32'd4,   1'b0, mk(3'd1, 5'd0,  32'd4,   32'd4,   32'd8, C_BR, 1'b0));

    // load-use on rs/rt: one stall cycle, one bubble, then issue
    run("lu_lw",   LW2,    32'h40, 32'd0, 1'b0, mk(3'd0, 5'd2, 32'h40, 32'd0, 32'd0, C_LW, 1'b0));
    run("lu_stall", ADD322, 32'd9, 32'd9, 1'b1, bub(1'b0));
    run("lu_issue", ADD322, 32'd9, 32'd9, 1'b0, mk(3'd0, 5'd3, 32'd9, 32'd9, 32'h1820, C_R, 1'b0));
    run("nd_lw",   LW2,    32'h40, 32'd0, 1'b0, mk(3'd0, 5'd2, 32'h40, 32'd0, 32'd0, C_LW, 1'b0));
    run("nd_add",  32'h00851820, 32'd4, 32'd5, 1'b0, mk(3'd0, 5'd3, 32'd4, 32'd5, 32'h1820, C_R, 1'b0));
    run("sw_lw",   LW2,    32'h40, 32'd0, 1'b0, mk(3'd0, 5'd2, 32'h40, 32'd0, 32'd0, C_LW, 1'b0));
    run("sw_stall", 32'hAC220004, 32'h40, 32'h77, 1'b1, bub(1'b0));
    run("sw_issue", 32'hAC220004, 32'h40, 32'h77, 1'b0, mk(3'd0, 5'd0, 32'h40, 32'h77, 32'd4, C_SW, 1'b0));
    // ori writes rt but never reads it: no hazard
    run("ori_lw",  LW2,    32'h40, 32'd0, 1'b0, mk(3'd0, 5'd2, 32'h40, 32'd0, 32'd0, C_LW, 1'b0));
    run("ori_nd",  32'h34220005, 32'h40, 32'd0, 1'b0, mk(3'd3, 5'd2, 32'h40, 32'd0, 32'd5, C_IMM, 1'b0));
    // load into x0 never stalls
    run("x0_lw",   32'h8C200000, 32'h40, 32'd0, 1'b0, mk(3'd0, 5'd0, 32'h40, 32'd0, 32'd0, C_LW, 1'b0));
    run("x0_add",  32'h00001820, 32'd0,  32'd0, 1'b0, mk(3'd0, 5'd3, 32'd0, 32'd0, 32'h1820, C_R, 1'b0));

    // writeback bypass
    step("byp_rs",  32'h00221820, 1'b1, 1'b0, 32'd5, 32'd7, 1'b1, 5'd1, 32'hDEAD, 1'b0,
         mk(3'd0, 5'd3, 32'hDEAD, 32'd7, 32'h1820, C_R, 1'b0));
    step("byp_rt",  32'h00221820, 1'b1, 1'b0, 32'd5, 32'd7, 1'b1, 5'd2, 32'hBEEF, 1'b0,
         mk(3'd0, 5'd3, 32'd5, 32'hBEEF, 32'h1820, C_R, 1'b0));
    step("byp_x0",  32'h00021820, 1'b1, 1'b0, 32'd0, 32'd7, 1'b1, 5'd0, 32'hDEAD, 1'b0,
         mk(3'd0, 5'd3, 32'd0, 32'd7, 32'h1820, C_R, 1'b0));
    step("byp_off", 32'h00221820, 1'b1, 1'b0, 32'd5, 32'd7, 1'b0, 5'd1, 32'hDEAD, 1'b0,
         mk(3'd0, 5'd3, 32'd5, 32'd7, 32'h1820, C_R, 1'b0));

    // flush beats a load-use hazard; afterwards the FSM behaves from RUN
    run("fl_lw",   LW2, 32'h40, 32'd0, 1'b0, mk(3'd0, 5'd2, 32'h40, 32'd0, 32'd0, C_LW, 1'b0));
    step("fl_kill", ADD322, 1'b1, 1'b1, 32'd9, 32'd9, 1'b0, 5'd0, 32'd0, 1'b0, bub(1'b0));
    run("fl_lw2",  LW2, 32'h40, 32'd0, 1'b0, mk(3'd0, 5'd2, 32'h40, 32'd0, 32'd0, C_LW, 1'b0));
    run("fl_stall", ADD322, 32'd9, 32'd9, 1'b1, bub(1'b0));
    run("fl_issue", ADD322, 32'd9, 32'd9, 1'b0, mk(3'd0, 5'd3, 32'd9, 32'd9, 32'h1820, C_R, 1'b0));

    // bubbles and the sticky illegal flag
    step("inv_bad", 32'hFC000000, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, bub(1'b0));
    run("nop",      32'h00000000, 32'd0, 32'd0, 1'b0, bub(1'b0));
    step("fl_bad",  32'hFC000000, 1'b1, 1'b1, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, bub(1'b0));
    run("bad_op",   32'hFC000000, 32'd0, 32'd0, 1'b0, bub(1'b1));
    run("ill_keep", 32'h00221820, 32'd5, 32'd7, 1'b0, mk(3'd0, 5'd3, 32'd5, 32'd7, 32'h1820, C_R, 1'b1));
    run("bad_fn",   32'h00221821, 32'd5, 32'd7, 1'b0, bub(1'b1));
    run("pre_rst",  32'h00221820, 32'd5, 32'd7, 1'b0, mk(3'd0, 5'd3, 32'd5, 32'd7, 32'h1820, C_R, 1'b1));

    // asynchronous reset mid-cycle clears everything immediately
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    run("post_rst", 32'h00221820, 32'd5, 32'd7, 1'b0, mk(3'd0, 5'd3, 32'd5, 32'd7, 32'h1820, C_R, 1'b0));

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter: WB_BYPASS, default 1, 1 = forward same-cycle writeback data into operand read, 0 = no bypass.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: if_valid  input  1  instr holds a valid fetched instruction.
REQ-005 Port: instr  input  32  instruction word, held stable by IF while stall_if=1.
REQ-006 Port: flush  input  1  branch resolved taken in EX; kill the ID instruction.
REQ-007 Port: rs, rt  output  5 each  register-file read addresses, instr[25:21] and instr[20:16], combinational.
REQ-008 Port: rs_data, rt_data  input  32 each  register-file read data, x0 already reads 0.
REQ-009 Port: wb_reg_write, wb_rd, wb_data  input  1/5/32  write port currently driving the register file.
REQ-010 Port: stall_if  output  1  hold PC and instr this cycle.
REQ-011 Port: ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_branch  output  1 each  ID/EX control.
REQ-012 Port: ex_alu_op  output  3  0=ADD 1=SUB 2=AND 3=OR 4=SLT.
REQ-013 Port: ex_rs_val, ex_rt_val, ex_imm  output  32 each  operands and extended immediate.
REQ-014 Port: ex_dest  output  5  destination register; ex_illegal output 1 sticky illegal-opcode flag.

Function
REQ-015 Decode: opcode 0x00 with funct 0x20/0x22/0x24/0x25/0x2A -> ADD/SUB/AND/OR/SLT, dest=rd, reg_write=1, alu_src=0.
REQ-016 Decode: 0x08 addi ADD, 0x0C andi AND, 0x0D ori OR; dest=rt, alu_src=1, reg_write=1.
REQ-017 Decode: 0x23 lw ADD, mem_read=1, dest=rt, reg_write=1; 0x2B sw ADD, mem_write=1, reg_write=0; 0x04 beq SUB, branch=1, reg_write=0.
REQ-018 Immediate: sign-extend instr[15:0] except andi/ori, which zero-extend.
REQ-019 instr==0 (nop), or any other opcode/funct, registers a bubble: ex_valid=0 and all ex_* control bits 0.
REQ-020 Unsupported opcode/funct with if_valid=1 sets ex_illegal; it stays 1 until reset.
REQ-021 Any bubble also forces ex_reg_write, ex_mem_read, ex_mem_write and ex_branch to 0.
REQ-022 Bypass (WB_BYPASS=1): if wb_reg_write and wb_rd!=0 and wb_rd==rs, capture wb_data into ex_rs_val instead of rs_data; same rule for rt.
REQ-023 rs is used by every supported instruction; rt is used only by R-type, sw and beq.
REQ-024 Load-use hazard: ex_valid & ex_mem_read & ex_dest!=0 & ex_dest matches a used source of the current valid instruction.
REQ-025 FSM states RUN and LU_STALL; RUN -> LU_STALL on hazard, LU_STALL -> RUN unconditionally after 1 cycle.
REQ-026 On hazard entry, stall_if=1 combinationally in that cycle and the next edge loads a bubble; in LU_STALL the held instruction issues normally.
REQ-027 A load followed by a dependent instruction costs exactly one bubble; the EX stage forwards the load result afterwards.
REQ-028 flush has priority over stall and decode: next edge loads a bubble, state -> RUN, stall_if=0 in that cycle.
REQ-029 if_valid=0 registers a bubble and sets no illegal flag.
REQ-030 All ex_* outputs are registered and change only on a clk rising edge or on reset.

Reset
REQ-031 rst_n low asynchronously clears all ex_* outputs, ex_illegal and data fields to 0 and forces state RUN.
REQ-032 An instruction in flight when reset asserts is discarded; the first edge after release decodes the current instr.

Verification
REQ-033 add $3,$1,$2 (0x00221820) with rs_data=5, rt_data=7 -> next edge ex_valid=1, alu_op=0, ex_dest=3, ex_rs_val=5, ex_rt_val=7, reg_write=1.
REQ-034 ori $4,$0,0x8001 -> ex_imm=0x00008001, alu_src=1; addi with imm 0x8001 -> ex_imm=0xFFFF8001.
REQ-035 lw $2,0($1), then add $3,$2,$2 -> stall_if=1 for one cycle, one bubble, add issues next edge; add $3,$4,$5 after lw gives no stall.
REQ-036 wb_reg_write=1, wb_rd=1, wb_data=0xDEAD with instr reading $1 -> ex_rs_val=0xDEAD; with wb_rd=0 -> rs_data used.
REQ-037 flush=1 during a load-use hazard -> bubble, stall_if=0, state RUN; opcode 0x3F -> bubble, ex_illegal=1 until rst_n low.
